// File: rtl/param_ping_pong_counter.sv
// Bounded up/down counter with run-time min/max, bounce or wrap mode and a
// registered boundary pulse. Define PPC_FLIP_EN to add the per-step direction-flip input.
module param_ping_pong_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET_n,
  input  logic             enable,
  input  logic             mode,
  input  logic [WIDTH-1:0] min,
  input  logic [WIDTH-1:0] max,
`ifdef PPC_FLIP_EN
  input  logic             flip,
`endif
  output logic             direction,
  output logic [WIDTH-1:0] out,
  output logic             bound
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_out;
  logic             r_dir;
  logic             r_bound;

  logic             w_flip;
  logic             w_legal;
  logic             w_in_range;
  logic             w_d;
  logic [WIDTH-1:0] w_out_nxt;
  logic             w_dir_nxt;
  logic             w_bound_nxt;

`ifdef PPC_FLIP_EN
  assign w_flip = flip;
`else
  assign w_flip = 1'b0;
`endif

  assign w_legal    = (max > min);
  assign w_in_range = (r_out >= min) && (r_out <= max);
  // Flip is applied before the boundary rules, so a flip at a bound bounces off it.
  assign w_d        = r_dir ^ w_flip;

  always_comb begin
    w_out_nxt   = r_out;
    w_dir_nxt   = r_dir;
    w_bound_nxt = 1'b0;
    if (enable && w_legal) begin
      if (!w_in_range) begin
        w_out_nxt = min;
        w_dir_nxt = 1'b1;
      end else if (mode) begin
        w_dir_nxt = w_d;
        if (w_d) begin
          if (r_out == max) begin
            w_out_nxt   = min;
            w_bound_nxt = 1'b1;
          end else begin
            w_out_nxt = r_out + ONE;
          end
        end else begin
          if (r_out == min) begin
            w_out_nxt   = max;
            w_bound_nxt = 1'b1;
          end else begin
            w_out_nxt = r_out - ONE;
          end
        end
      end else begin
        if (w_d) begin
          if (r_out == max) begin
            w_out_nxt   = max - ONE;
            w_dir_nxt   = 1'b0;
            w_bound_nxt = 1'b1;
          end else begin
            w_out_nxt = r_out + ONE;
            w_dir_nxt = 1'b1;
          end
        end else begin
          if (r_out == min) begin
            w_out_nxt   = min + ONE;
            w_dir_nxt   = 1'b1;
            w_bound_nxt = 1'b1;
          end else begin
            w_out_nxt = r_out - ONE;
            w_dir_nxt = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_out   <= '0;
      r_dir   <= 1'b1;
      r_bound <= 1'b0;
    end else begin
      r_out   <= w_out_nxt;
      r_dir   <= w_dir_nxt;
      r_bound <= w_bound_nxt;
    end
  end

  assign out       = r_out;
  assign direction = r_dir;
  assign bound     = r_bound;

endmodule

// File: doc/param_ping_pong_counter.md
# param_ping_pong_counter

Parametrised bounded up/down counter for the lab datapath, driving the seven-segment and LED display paths. Generalises the fixed 4-bit ping-pong counter:
- configurable width;
- run-time min/max bounds;
- selectable bounce (ping-pong) or wrap (sawtooth) mode;
- registered boundary pulse;
- optional direction-flip input.

All state lives in one clock domain.

## Interface
- WIDTH, 4: counter and bound width in bits (≥2).
- CLK  in  1  rising-edge clock.
- RESET_n  in  1  asynchronous, active-low reset.
- enable  in  1  step enable; low = hold.
- mode  in  1  0 = ping-pong (bounce), 1 = wrap.
- min  in  WIDTH  lower bound (unsigned), sampled every edge.
- max  in  WIDTH  upper bound (unsigned), sampled every edge.
- flip  in  1  invert direction this step. Present only when PPC_FLIP_EN is defined.
- direction  out  1  1 = counting up, 0 = counting down (registered).
- out  out  WIDTH  counter value (registered).
- bound  out  1  one-cycle pulse: the last edge bounced or wrapped (registered).

## Operation
- Reset (RESET_n low, any time, asynchronous): out = 0, direction = 1, bound = 0. The counter resumes on the first rising edge after release.
- Legal range: max > min (unsigned). If max ≤ min, hold out and direction and set bound = 0, regardless of enable.
- enable = 0: hold out and direction; bound = 0.
- enable = 1 with out outside [min, max]: resynchronise. out ← min, direction ← 1, bound ← 0. This also covers the first step after reset when min > 0, and bounds changed mid-run.
- enable = 1 with out in range: take a step with effective direction d.
  - d = direction, or ~direction when flip = 1.
- Ping-pong mode (mode = 0):
  - d = 1, out < max: out + 1, direction ← 1.
  - d = 1, out = max: out ← max − 1, direction ← 0, bound ← 1.
  - d = 0, out > min: out − 1, direction ← 0.
  - d = 0, out = min: out ← min + 1, direction ← 1, bound ← 1.
- Wrap mode (mode = 1):
  - d = 1: out + 1, or min when out = max (bound ← 1).
  - d = 0: out − 1, or max when out = min (bound ← 1).
  - direction ← d.
- Arithmetic is unsigned, WIDTH bits. No step ever leaves [min, max], so there is no overflow.
- A mode change takes effect on the next enabled edge. Current out and direction are kept.
- Simultaneous flip at a bound: the flip applies first, then the bound rule. Example: flip at out = max while direction = 0 gives d = 1, so the counter bounces to max − 1 with direction = 0 and bound = 1.

## Timing
- One step per enabled rising edge. Inputs sampled on that edge; outputs valid after it. Latency from input to out/direction/bound is 1 cycle.
- bound stays high for exactly one cycle per boundary event. On consecutive boundary events (max − min = 1, ping-pong) it stays high.
- No combinational path from any input to any output.
- Reset assertion clears outputs immediately, without waiting for a clock edge.

## Configuration
- PPC_FLIP_EN defined:
  - flip port exists.
  - Flip is honoured only when enable = 1 and out is in range.
  - flip is ignored in the hold, illegal-range and resync cases.
- PPC_FLIP_EN undefined:
  - flip port removed.
  - Effective direction d always equals direction.
  - All other behaviour is identical.

## Test plan
- WIDTH = 4, min = 0, max = 15, mode = 0, reset pulse then enable = 1 → out 0,1,…,15,14,…,0,1. bound high on the cycles showing 14 and 1. direction falls with out = 14.
- min = 3, max = 6, mode = 0, enable from reset (out = 0) → out 3,4,5,6,5,4,3,4. The first step resyncs to 3 with bound = 0.
- min = 2, max = 5, mode = 1, direction up → out 2,3,4,5,2,3. bound high on the cycle showing the second 2. direction constant at 1.
- enable low for 4 cycles at out = 9 → out and direction held, bound = 0. Set max = 4, min = 7 (illegal) with enable = 1 → still held.
- PPC_FLIP_EN, min = 0, max = 15, mode = 0, out = 15, direction = 0, flip = 1 → out 14, direction 0, bound 1. At out = 8 going up, flip → out 7, direction 0.
- Assert RESET_n mid-count at out = 11 between edges → out = 0 and direction = 1 immediately. After release with min = 0, max = 15, enable = 1 → out 1 on the next edge.
